// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pong game logic and its side blocks.
// The state-streaming UART adds its frame constants, tx FSM encoding and
// frame-byte helpers here. Build option: GAME_TX_PARITY_EN adds an
// even-parity bit to every transmitted byte.
package vga_pkg;

  // Game logic FSM encodings, reused by the state streamer.
  typedef enum logic [1:0] {
    MENU_START = 2'b00,
    PLAY       = 2'b01,
    GAME_OVER  = 2'b10
  } game_state_t;

  localparam int         FRAME_LEN         = 10;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte serializer states; the parity state exists only in the parity build.
`ifdef GAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
  } tx_state_t;
`endif

  // Frame sequencer states.
  typedef enum logic [1:0] {
    FRAME_IDLE, FRAME_SEND, FRAME_DONE
  } frame_state_t;

  // Captured copy of the game-logic outputs for one frame.
  typedef struct packed {
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [9:0]  y_player_1;
    logic [3:0]  player1_score;
    logic [3:0]  player2_score;
    logic        still_graphic;
    game_state_t game_state;
  } game_snapshot_t;

  // Payload bytes 1..8 (anything else returns 0).
  function automatic logic [7:0] payload_byte(input game_snapshot_t s,
                                              input logic [3:0] idx);
    case (idx)
      4'd1:    payload_byte = {5'b0, s.x_ball[10:8]};
      4'd2:    payload_byte = s.x_ball[7:0];
      4'd3:    payload_byte = {6'b0, s.y_ball[9:8]};
      4'd4:    payload_byte = s.y_ball[7:0];
      4'd5:    payload_byte = {6'b0, s.y_player_1[9:8]};
      4'd6:    payload_byte = s.y_player_1[7:0];
      4'd7:    payload_byte = {s.player1_score, s.player2_score};
      4'd8:    payload_byte = {5'b0, s.still_graphic, s.game_state};
      default: payload_byte = 8'h00;
    endcase
  endfunction

  // XOR of payload bytes 1..8.
  function automatic logic [7:0] frame_checksum(input game_snapshot_t s);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i <= 8; i++) c ^= payload_byte(s, 4'(i));
    return c;
  endfunction

  // Full frame byte by index: sync, payload, checksum.
  function automatic logic [7:0] frame_byte(input game_snapshot_t s,
                                            input logic [3:0] idx,
                                            input logic [7:0] sync);
    if (idx == 4'd0)                     frame_byte = sync;
    else if (idx == 4'(FRAME_LEN - 1))   frame_byte = frame_checksum(s);
    else                                 frame_byte = payload_byte(s, idx);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-level UART serializer: start bit, 8 data bits LSB first, optional
// even parity (GAME_TX_PARITY_EN), stop bit. A start strobe in the last
// cycle of a stop bit chains the next byte with no idle gap.
module uart_tx_byte
  import vga_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_wrap;
`ifdef GAME_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign baud_wrap = (baud_cnt == BAUD_MAX);
  // Asserted in the final cycle of the stop bit so the caller can chain.
  assign byte_done = (state == TX_STOP) && baud_wrap;

  // Bit sequencing with the baud counter; the bit advances on counter wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef GAME_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (start) begin
      state    <= TX_START;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data;
`ifdef GAME_TX_PARITY_EN
      parity_bit <= ^data;
`endif
    end else if (state == TX_IDLE || state == TX_DONE) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
    end else if (!baud_wrap) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        TX_START: begin
          state   <= TX_DATA;
          tx      <= shreg[0];
          bit_cnt <= '0;
        end
        TX_DATA: begin
          if (bit_cnt == 3'd7) begin
`ifdef GAME_TX_PARITY_EN
            state <= TX_PARITY;
            tx    <= parity_bit;
`else
            state <= TX_STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
            tx      <= shreg[1];
          end
        end
`ifdef GAME_TX_PARITY_EN
        TX_PARITY: begin
          state <= TX_STOP;
          tx    <= 1'b1;
        end
`endif
        TX_STOP: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_state_uart_tx.sv
// Streams a snapshot of the game-logic outputs as a 10-byte UART frame
// (sync, x, y, pad, scores, state/still, checksum) once per accepted
// timing_tick. Read-only tap on the logic block.
// Build option: GAME_TX_PARITY_EN selects 8E1 framing instead of 8N1.
module game_state_uart_tx
  import vga_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 564,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        enable,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  input  logic [9:0]  y_player_1,
  input  logic [3:0]  player1_score,
  input  logic [3:0]  player2_score,
  input  logic [1:0]  game_state,
  input  logic        still_graphic,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_drop
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  frame_state_t   state;
  game_snapshot_t snap;
  logic [3:0]     byte_idx;
  logic           capture;
  logic           byte_done;
  logic           byte_start;
  logic [7:0]     byte_data;

  assign capture = timing_tick && enable && !busy;

  // Pick the byte to launch: sync on capture, else the next frame byte
  // when the current stop bit is finishing.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    byte_start = 1'b0;
    byte_data  = SYNC_BYTE;
    if (capture) begin
      byte_start = 1'b1;
    end else if (state == FRAME_SEND && byte_done && byte_idx != LAST_IDX) begin
      byte_start = 1'b1;
      byte_data  = frame_byte(snap, 4'(byte_idx + 4'd1), SYNC_BYTE);
    end
  end

  // Frame sequencer: capture, byte indexing, done/drop pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FRAME_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      byte_idx   <= '0;
      snap       <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_drop <= timing_tick && enable && busy;
      case (state)
        FRAME_SEND: begin
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              state      <= FRAME_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              byte_idx   <= '0;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a tick, since busy is already low.
          if (capture) begin
            state    <= FRAME_SEND;
            busy     <= 1'b1;
            byte_idx <= '0;
            snap     <= '{x_ball:        x_ball,
                          y_ball:        y_ball,
                          y_player_1:    y_player_1,
                          player1_score: player1_score,
                          player2_score: player2_score,
                          still_graphic: still_graphic,
                          game_state:    game_state_t'(game_state)};
          end else begin
            state <= FRAME_IDLE;
          end
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_game_state_uart_tx.sv
// Directed bench for game_state_uart_tx at CLKS_PER_BIT=4.
module tb_game_state_uart_tx;

  localparam int CPB = 4;
`ifdef GAME_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME_CYC = 10 * BPB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic        enable;
  logic [10:0] x_ball;
  logic [9:0]  y_ball;
  logic [9:0]  y_player_1;
  logic [3:0]  player1_score;
  logic [3:0]  player2_score;
  logic [1:0]  game_state;
  logic        still_graphic;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic        frame_drop;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_bytes [10];
  logic       rx_par   [10];
  int         drops;

  logic [7:0] exp_nominal [10] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h80,
                                   8'h01, 8'h50, 8'h35, 8'h01, 8'hE6};
  logic [7:0] exp_alt     [10] = '{8'hA5, 8'h07, 8'hFF, 8'h03, 8'hFF,
                                   8'h00, 8'h00, 8'h9F, 8'h06, 8'h9D};

  always #5 clk = ~clk;

  game_state_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .timing_tick  (timing_tick),
    .enable       (enable),
    .x_ball       (x_ball),
    .y_ball       (y_ball),
    .y_player_1   (y_player_1),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .game_state   (game_state),
    .still_graphic(still_graphic),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_drop   (frame_drop)
  );

  task automatic set_nominal();
    x_ball        = 11'd512;
    y_ball        = 10'd384;
    y_player_1    = 10'h150;
    player1_score = 4'd3;
    player2_score = 4'd5;
    game_state    = 2'b01;
    still_graphic = 1'b0;
  endtask

  // Receives one frame. With do_tick it issues the capturing tick itself;
  // otherwise the caller has just passed the capture edge (+1 ns).
  // Ends at the DONE cycle (+1 ns after the edge that closes the frame).
  task automatic run_frame(input string name, input bit do_tick,
                           input int tick2_at, input int xchg_at,
                           input logic [10:0] xnew);
    int start_err, stop_err, busy_low, early_done;
    start_err = 0; stop_err = 0; busy_low = 0; early_done = 0; drops = 0;
    if (do_tick) begin
      @(negedge clk); timing_tick = 1'b1;
      @(posedge clk); #1; timing_tick = 1'b0;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: tx=%b busy=%b, required tx=0 busy=1", name, tx, busy);
    end
    for (int k = 0; k < FRAME_CYC; k++) begin
      int b, byte_i, bit_i;
      b = k / CPB;
      if (k % CPB == CPB / 2) begin
        byte_i = b / BPB;
        bit_i  = b % BPB;
        if (bit_i == 0) begin
          if (tx !== 1'b0) start_err++;
        end else if (bit_i <= 8) begin
          rx_bytes[byte_i][bit_i-1] = tx;
        end else if (BPB == 11 && bit_i == 9) begin
          rx_par[byte_i] = tx;
        end else begin
          if (tx !== 1'b1) stop_err++;
        end
      end
      if (frame_drop === 1'b1) drops++;
      if (busy !== 1'b1) busy_low++;
      if (frame_done !== 1'b0) early_done++;
      if (k == tick2_at) timing_tick = 1'b1;
      else if (k == tick2_at + 1) timing_tick = 1'b0;
      if (k == xchg_at) x_ball = xnew;
      @(posedge clk); #1;
    end
    checks++;
    if (start_err != 0 || stop_err != 0) begin
      errors++;
      $display("FAIL %s framing: start_err=%0d stop_err=%0d, required 0/0", name, start_err, stop_err);
    end
    checks++;
    if (busy_low != 0 || early_done != 0) begin
      errors++;
      $display("FAIL %s busy/done during frame: busy_low=%0d early_done=%0d, required 0/0",
               name, busy_low, early_done);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s end at +%0d: frame_done=%b busy=%b tx=%b, required 1/0/1",
               name, FRAME_CYC, frame_done, busy, tx);
    end
  endtask

  task automatic compare_bytes(input string name, input logic [7:0] expv [10]);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_bytes[i] !== expv[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h, required %h", name, i, rx_bytes[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || frame_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b done=%b drop=%b, required 1/0/0/0",
               tx, busy, frame_done, frame_drop);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal();
    set_nominal();
    run_frame("nominal", 1'b1, -1, -1, 11'd0);
    compare_bytes("nominal", exp_nominal);
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal done_pulse_width: frame_done=%b, required 0", frame_done);
    end
`ifdef GAME_TX_PARITY_EN
    checks++;
    if (rx_par[0] !== 1'b0 || rx_par[8] !== 1'b1) begin
      errors++;
      $display("FAIL parity A5/01: got %b/%b, required 0/1", rx_par[0], rx_par[8]);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_par[i] !== ^exp_nominal[i]) begin
        errors++;
        $display("FAIL parity byte%0d: got %b, required %b", i, rx_par[i], ^exp_nominal[i]);
      end
    end
`endif
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tick_while_busy();
    int extra_busy;
    extra_busy = 0;
    set_nominal();
    run_frame("busy_tick", 1'b1, 50, -1, 11'd0);
    compare_bytes("busy_tick", exp_nominal);
    checks++;
    if (drops != 1) begin
      errors++;
      $display("FAIL busy_tick frame_drop pulses: got %0d, required 1", drops);
    end
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || tx !== 1'b1) extra_busy++;
    end
    checks++;
    if (extra_busy != 0) begin
      errors++;
      $display("FAIL busy_tick second_frame: active cycles=%0d, required 0", extra_busy);
    end
  endtask

  task automatic test_input_change();
    set_nominal();
    run_frame("mid_change", 1'b1, -1, 10, 11'h7FF);
    compare_bytes("mid_change", exp_nominal);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    set_nominal();
    @(negedge clk); timing_tick = 1'b1;
    @(posedge clk); #1; timing_tick = 1'b0;
    repeat (120) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset immediate: tx=%b busy=%b, required 1/0", tx, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset resume: active cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    set_nominal();
    enable = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); timing_tick = 1'b1;
      @(negedge clk); timing_tick = 1'b0;
      for (int k = 0; k < 15; k++) begin
        @(posedge clk); #1;
        if (tx !== 1'b1 || frame_drop !== 1'b0 || busy !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL enable_off: bad cycles=%0d, required 0", bad);
    end
    enable = 1'b1;
    run_frame("enable_on", 1'b1, -1, -1, 11'd0);
    compare_bytes("enable_on", exp_nominal);
  endtask

  // A tick in the DONE cycle starts the next frame right away.
  task automatic test_back_to_back();
    set_nominal();
    run_frame("b2b_first", 1'b1, -1, -1, 11'd0);
    x_ball        = 11'h7FF;
    y_ball        = 10'h3FF;
    y_player_1    = 10'h000;
    player1_score = 4'd9;
    player2_score = 4'hF;
    game_state    = 2'b10;
    still_graphic = 1'b1;
    timing_tick   = 1'b1;
    @(posedge clk); #1;
    timing_tick = 1'b0;
    checks++;
    if (frame_drop !== 1'b0) begin
      errors++;
      $display("FAIL b2b frame_drop on done tick: got %b, required 0", frame_drop);
    end
    run_frame("b2b_second", 1'b0, -1, -1, 11'd0);
    compare_bytes("b2b_second", exp_alt);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    timing_tick = 1'b0;
    enable      = 1'b1;
    set_nominal();
    test_reset();
    test_nominal();
    test_tick_while_busy();
    test_input_change();
    test_mid_reset();
    test_enable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_uart_tx.md
Name: game_state_uart_tx

Overview:
- Reads the game-logic outputs (ball position, left pad, scores, FSM state, still_graphic) and streams them as a framed UART packet.
- A second board or a PC monitor consumes the packet, which gives the second-player or remote-display path a serialized copy of game state.
- One frame is captured per timing_tick.
- Sits beside the top-level logic block. It only reads the logic signals and never drives them.

Parameters:
- CLKS_PER_BIT, 564, clock cycles per UART bit (65 MHz / 115200 baud, truncated). Legal range ≥ 4.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- timing_tick  input  1  frame-rate strobe, one cycle wide
- enable  input  1  high = capture and send frames on ticks
- x_ball  input  11  ball x
- y_ball  input  10  ball y
- y_player_1  input  10  left pad y
- player1_score  input  4  left score
- player2_score  input  4  right score
- game_state  input  2  logic FSM state (menu_start/play/game_over encodings from vga_pkg)
- still_graphic  input  1  freeze flag
- tx  output  1  UART line, idle high
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse at the end of a frame
- frame_drop  output  1  one-cycle pulse when a tick is ignored because busy

Interface (already decided): one clock, clk; reset is rst, asynchronous and active-high.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, frame_done=0, frame_drop=0. Byte index, bit counter and baud counter clear to 0. Snapshot register clears to 0.
- Reset mid-frame: tx returns high at once. No partial frame resumes after reset release.
- Capture: in a cycle with timing_tick=1, enable=1 and busy=0, all inputs are registered into the snapshot. The FSM leaves IDLE.
- Latency: tx falls to the start bit on the next clock edge (cycle T+1). busy=1 from T+1.
- Tick with busy=1: no capture, frame_drop=1 for that one cycle, current frame unaffected.
- Tick with enable=0: ignored silently, no frame_drop.
- enable dropping mid-frame: the current frame completes.
- Frame is 10 bytes, sent in index order (multi-bit fields high byte first, zero-padded):
  - 0: SYNC_BYTE
  - 1: {5'b0, x[10:8]}
  - 2: x[7:0]
  - 3: {6'b0, y[9:8]}
  - 4: y[7:0]
  - 5: {6'b0, pad[9:8]}
  - 6: pad[7:0]
  - 7: {p1_score, p2_score}
  - 8: {5'b0, still_graphic, game_state}
  - 9: checksum = XOR of bytes 1..8
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Bytes are back-to-back, with no idle gap between one stop bit and the next start bit.
- Frame duration: 100·CLKS_PER_BIT cycles (110· with parity).
- FSM states:
  - IDLE: tx=1. On a valid tick, go to START.
  - START → DATA(8 bits) → [PARITY] → STOP.
  - From STOP: if byte index < 9, increment the index and go to START; else go to DONE.
  - DONE: one cycle, frame_done=1, busy=0, returns to IDLE.
- A tick in the DONE cycle is accepted, because busy is already 0.
- Snapshot inputs may change freely during transmission. Only captured values are sent.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit advances on the wrap.

Optional Feature:
- Macro: GAME_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the data and stop bits. That gives 11 bits per byte and 110·CLKS_PER_BIT cycles per frame.
- Undefined: 8N1 framing, no parity state present in the FSM.

Decomposition:
- vga_pkg gains:
  - the frame-length constant (10);
  - the default SYNC_BYTE value;
  - a tx FSM state enum (TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE).
- vga_pkg already holds the game-state encodings, which this block reuses.
- Sub-module uart_tx_byte: byte-level serializer with the baud counter.
  - Inputs: byte + start strobe.
  - Outputs: tx, byte_done.
- game_state_uart_tx owns the snapshot, the byte multiplexer, the checksum and the frame sequencing.

Test Plan:
- Nominal frame, with CLKS_PER_BIT=4, x=512, y=384, pad=0x150, scores 3/5, state=play(01), still=0, one tick:
  - Required bytes: A5 02 00 01 80 01 50 35 01 E6.
  - frame_done pulses at T+1+400.
- Tick while busy (second tick at T+50): frame_drop=1 for one cycle, the byte stream is identical to the nominal case, and no second frame follows.
- Input change mid-frame (x changed to 0x7FF at T+10): transmitted x bytes are still 02 00, and the checksum is still E6.
- Async reset at T+120 mid-byte: tx=1 within the same cycle and busy=0. After release with no tick, tx stays high for 200 cycles.
- enable=0 with ticks: tx stays 1 and frame_drop stays 0. Setting enable=1 then ticking starts a frame on the next clock.
- Parity build (GAME_TX_PARITY_EN): byte 0xA5 has parity bit 0; byte 0x01 has parity bit 1. Frame length is 440 cycles at CLKS_PER_BIT=4.
